// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    localparam int         DEF_ADDR_W      = 8;
    localparam int         DEF_DATA_W      = 8;
    localparam logic [7:0] DEF_HALT_OPCODE = 8'hFF;
    localparam int         DEF_EXT_BIT     = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_OP  = 3'd1,
        ST_CAP_OP  = 3'd2,
        ST_REQ_ARG = 3'd3,
        ST_CAP_ARG = 3'd4,
        ST_OUT     = 3'd5,
        ST_HALT    = 3'd6
    } fetch_state_e;

    // An opcode with the extension bit set carries an operand word, except
    // the halt opcode, which always stands alone.
    function automatic logic is_two_word(input logic [DEF_DATA_W-1:0] opcode);
        return opcode[DEF_EXT_BIT] && (opcode != DEF_HALT_OPCODE);
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage between instr_mem and the decoder. Drives the
// instr_mem read address, assembles {opcode, operand} instructions and
// presents them downstream. Owns the PC, jump redirects and the halt opcode.
//
// Handshake: instr_valid is high only in OUT; instr and instr_pc are held
// stable while instr_valid is high and instr_ready is low; a transfer occurs
// on every rising edge where both are high, and instr_valid drops on the
// following cycle.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                DATA_W      = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] START_ADDR  = '0,
    parameter logic [DATA_W-1:0] HALT_OPCODE = DEF_HALT_OPCODE,
    parameter int                EXT_BIT     = DEF_EXT_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [DATA_W-1:0]   imem_data,
    output logic [2*DATA_W-1:0] instr,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                jump_en,
    input  logic [ADDR_W-1:0]   jump_addr,
    output logic                busy,
    output logic                halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] opcode_q, operand_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              cap_two_word;
    logic              out_two_word;

    // Word length of the opcode arriving now (CAP_OP) and of the one held.
    assign cap_two_word = imem_data[EXT_BIT] && (imem_data != HALT_OPCODE);
    assign out_two_word = opcode_q[EXT_BIT] && (opcode_q != HALT_OPCODE);

    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted      = (state_q == ST_HALT);
    assign instr_valid = (state_q == ST_OUT);
    assign instr       = {opcode_q, operand_q};
    assign instr_pc    = instr_pc_q;

    // Next state, next PC and the read address to present next cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = imem_addr;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_REQ_OP;
                    pc_d    = START_ADDR;
                end
            end
            ST_REQ_OP:  state_d = ST_CAP_OP;
            ST_CAP_OP:  state_d = cap_two_word ? ST_REQ_ARG : ST_OUT;
            ST_REQ_ARG: state_d = ST_CAP_ARG;
            ST_CAP_ARG: state_d = ST_OUT;
            ST_OUT: begin
                if (instr_ready) begin
                    pc_d    = pc_q + (out_two_word ? ADDR_W'(2) : ADDR_W'(1));
                    state_d = (opcode_q == HALT_OPCODE) ? ST_HALT : ST_REQ_OP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A redirect overrides everything in flight, including a handshake.
        if (jump_en && busy) begin
            state_d = ST_REQ_OP;
            pc_d    = jump_addr;
        end
        // The address changes only when a new request starts, so it stays
        // put across each request/capture pair and while presenting.
        if (state_d == ST_REQ_OP) begin
            addr_d = pc_d;
        end else if (state_d == ST_REQ_ARG) begin
            addr_d = pc_q + ADDR_W'(1);
        end
    end

    // State, PC and read-address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_ADDR;
            imem_addr <= START_ADDR;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            imem_addr <= addr_d;
        end
    end

    // Capture opcode/operand words as they return from instr_mem.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q   <= '0;
            operand_q  <= '0;
            instr_pc_q <= '0;
        end else if (state_q == ST_CAP_OP) begin
            opcode_q   <= imem_data;
            operand_q  <= '0;
            instr_pc_q <= pc_q;
        end else if (state_q == ST_CAP_ARG) begin
            operand_q  <= imem_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against a
// transaction-level model of the fetch stage.
module tb_instr_fetch;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        instr_ready = 1'b0;
    logic        jump_en = 1'b0;
    logic [7:0]  jump_addr = 8'h00;
    logic [7:0]  imem_addr, imem_data;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid, busy, halted;

    logic        start_w = 1'b0;
    logic [7:0]  imem_addr_w, imem_data_w;
    logic [15:0] instr_w;
    logic [7:0]  instr_pc_w;
    logic        instr_valid_w, busy_w, halted_w;

    logic [7:0]  mem   [256];
    logic [7:0]  mem_w [256];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // registered-read instruction memories
    always @(posedge clk) imem_data   <= mem[imem_addr];
    always @(posedge clk) imem_data_w <= mem_w[imem_addr_w];

    instr_fetch dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .jump_en(jump_en), .jump_addr(jump_addr),
        .busy(busy), .halted(halted)
    );

    instr_fetch #(.START_ADDR(8'hFF)) dut_w (
        .clk(clk), .rst(rst), .start(start_w),
        .imem_addr(imem_addr_w), .imem_data(imem_data_w),
        .instr(instr_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w),
        .instr_ready(1'b1), .jump_en(1'b0), .jump_addr(8'h00),
        .busy(busy_w), .halted(halted_w)
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model tracks the instruction being fetched (its PC) and how many
    // cycles have elapsed since its fetch began; an instruction is presented
    // once its words have had time to arrive (2 cycles, or 4 with operand).
    bit         m_active = 1'b0;
    bit         m_halted = 1'b0;
    logic [7:0] m_pc = 8'h00;
    int         m_age = 0;
    bit         cmp_en = 1'b0;

    function automatic bit spec_two_word(input logic [7:0] op);
        return op[7] && (op != 8'hFF);
    endfunction

    function automatic int m_fetch_cycles();
        return spec_two_word(mem[m_pc]) ? 4 : 2;
    endfunction

    function automatic bit m_valid();
        return m_active && (m_age >= m_fetch_cycles());
    endfunction

    function automatic logic [15:0] m_instr();
        logic [7:0] a;
        a = m_pc + 8'd1;
        return {mem[m_pc], spec_two_word(mem[m_pc]) ? mem[a] : 8'h00};
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_active = 1'b0; m_halted = 1'b0; m_pc = 8'h00; m_age = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1; m_halted = 1'b0; m_pc = 8'h00; m_age = 0;
            end
        end else if (jump_en) begin
            m_pc = jump_addr; m_age = 0;
        end else if (m_valid() && instr_ready) begin
            if (mem[m_pc] == 8'hFF) begin
                m_active = 1'b0; m_halted = 1'b1;
            end
            m_pc  = m_pc + (spec_two_word(mem[m_pc]) ? 8'd2 : 8'd1);
            m_age = 0;
        end else if (m_age < 8) begin
            m_age++;
        end
    end

    // compare process: DUT outputs against the model, every cycle
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("busy", 32'(busy), 32'(m_active));
            check("halted", 32'(halted), 32'(m_halted));
            check("instr_valid", 32'(instr_valid), 32'(m_valid()));
            if (m_valid()) begin
                check("instr", 32'(instr), 32'(m_instr()));
                check("instr_pc", 32'(instr_pc), 32'(m_pc));
                check("imem_addr_out", 32'(imem_addr),
                      32'(spec_two_word(mem[m_pc]) ? m_pc + 8'd1 : m_pc));
            end else if (m_active) begin
                check("imem_addr_fetch", 32'(imem_addr),
                      32'(m_age < 2 ? m_pc : m_pc + 8'd1));
            end
        end
    end

    // handshake monitors: {instr_pc, instr} per accepted instruction
    logic [23:0] got_q[$];
    logic [23:0] got_w_q[$];
    logic [23:0] exp_q[$];

    initial forever begin
        @(negedge clk);
        if (instr_valid === 1'b1 && instr_ready === 1'b1) got_q.push_back({instr_pc, instr});
        if (instr_valid_w === 1'b1) got_w_q.push_back({instr_pc_w, instr_w});
    end

    task automatic check_seq(input string name, input bit use_w);
        int n;
        n = use_w ? got_w_q.size() : got_q.size();
        check({name, "_count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < n) check(name, 32'(use_w ? got_w_q[i] : got_q[i]), 32'(exp_q[i]));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; start_w = 1'b0; jump_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (instr_valid !== 1'b1 && n < 40);
    endtask

    task automatic wait_halt(input string name);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(name, 32'(halted), 32'd1);
    endtask

    task automatic load_program();
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'h00;
            mem_w[i] = 8'h00;
        end
        mem[0] = 8'h12; mem[1] = 8'h85; mem[2] = 8'h3C; mem[3] = 8'h20; mem[4] = 8'hFF;
        mem_w[8'hFF] = 8'h90; mem_w[8'h00] = 8'h55; mem_w[8'h01] = 8'h07; mem_w[8'h02] = 8'hFF;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        load_program();
        do_reset();
        cmp_en = 1'b1;

        // reset values
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'h00);
        check("rst_instr", 32'(instr), 32'h0000);
        check("rst_instr_pc", 32'(instr_pc), 32'h00);
        check("rst_imem_addr_w", 32'(imem_addr_w), 32'hFF);

        // basic program, always ready
        instr_ready = 1'b1;
        got_q.delete();
        pulse_start();
        wait_valid(n);
        check("first_valid_latency", 32'(n), 32'd3);
        wait_halt("t1_halt");
        check("t1_busy_after_halt", 32'(busy), 32'd0);
        exp_q = '{24'h001200, 24'h01853C, 24'h032000, 24'h04FF00};
        check_seq("t1_seq", 1'b0);

        // backpressure on the first instruction
        do_reset();
        instr_ready = 1'b0;
        pulse_start();
        wait_valid(n);
        check("t2_latency", 32'(n), 32'd3);
        repeat (6) begin
            @(negedge clk);
            check("t2_hold_instr", 32'(instr), 32'h1200);
            check("t2_hold_pc", 32'(instr_pc), 32'h00);
            check("t2_hold_addr", 32'(imem_addr), 32'h00);
            check("t2_hold_valid", 32'(instr_valid), 32'd1);
        end
        tick();
        instr_ready = 1'b1;
        @(negedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (instr_valid !== 1'b1 && n < 20);
        check("t2_next_latency", 32'(n), 32'd5);
        check("t2_next_instr", 32'(instr), 32'h853C);
        check("t2_next_pc", 32'(instr_pc), 32'h01);
        wait_halt("t2_halt");

        // jump during operand capture of the 0x85 fetch
        do_reset();
        instr_ready = 1'b1;
        got_q.delete();
        pulse_start();
        repeat (6) tick();
        jump_en = 1'b1; jump_addr = 8'h03;
        tick();
        jump_en = 1'b0;
        wait_halt("t3_halt");
        exp_q = '{24'h001200, 24'h032000, 24'h04FF00};
        check_seq("t3_seq", 1'b0);

        // START_ADDR=0xFF with operand wrapping to 0x00
        do_reset();
        got_w_q.delete();
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        n = 0;
        while (halted_w !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("t4_halt_w", 32'(halted_w), 32'd1);
        exp_q = '{24'hFF9055, 24'h010700, 24'h02FF00};
        check_seq("t4_seq", 1'b1);

        // reset during operand request
        do_reset();
        instr_ready = 1'b1;
        pulse_start();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid", 32'(instr_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_imem_addr", 32'(imem_addr), 32'h00);
        check("t5_instr", 32'(instr), 32'h0000);
        check("t5_instr_pc", 32'(instr_pc), 32'h00);
        pulse_start();
        wait_valid(n);
        check("t5_refetch_instr", 32'(instr), 32'h1200);
        check("t5_refetch_pc", 32'(instr_pc), 32'h00);
        wait_halt("t5_halt");

        // start while busy, start while halted, jump while halted
        do_reset();
        got_q.delete();
        instr_ready = 1'b0;
        pulse_start();
        wait_valid(n);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        instr_ready = 1'b1;
        wait_halt("t6_halt");
        exp_q = '{24'h001200, 24'h01853C, 24'h032000, 24'h04FF00};
        check_seq("t6_seq", 1'b0);
        pulse_start();
        wait_valid(n);
        check("t6_restart_instr", 32'(instr), 32'h1200);
        check("t6_restart_pc", 32'(instr_pc), 32'h00);
        wait_halt("t6_halt2");
        jump_en = 1'b1; jump_addr = 8'h01;
        tick();
        jump_en = 1'b0;
        check("t6_jump_in_halt", 32'(halted), 32'd1);
        check("t6_jump_in_halt_busy", 32'(busy), 32'd0);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 256; i++) begin
            mem[i] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        end
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            start       = ($urandom_range(0, 7) == 0);
            jump_en     = ($urandom_range(0, 15) == 0);
            jump_addr   = 8'($urandom_range(0, 255));
            rst         = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; jump_en = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
